// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg_pkg: shared types and constants for the oscilloscope command
// dispatcher: FSM state encoding, opcodes, response codes, slave selects
// and the gain-code to DAC-value lookup.
package cmd_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      SPI_WAIT,
      DUMP_WAIT,
      RESP,
      RESP_WAIT
   } state_t;

   // Host opcodes
   localparam logic [7:0] OP_DUMP     = 8'h01;
   localparam logic [7:0] OP_GAIN     = 8'h02;
   localparam logic [7:0] OP_TRIG_LVL = 8'h03;
   localparam logic [7:0] OP_TRIG_POS = 8'h04;
   localparam logic [7:0] OP_DEC      = 8'h05;
   localparam logic [7:0] OP_TRIG_CFG = 8'h06;
   localparam logic [7:0] OP_CFG_RD   = 8'h07;
   localparam logic [7:0] OP_EEP_WR   = 8'h08;
   localparam logic [7:0] OP_EEP_RD   = 8'h09;
   localparam logic [7:0] OP_GAIN_RD  = 8'h0A;

   // Response bytes
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;

   // SPI slave selects (channels 0..3 use ss = channel number)
   localparam logic [2:0] SS_NONE = 3'b111;
   localparam logic [2:0] SS_EEP  = 3'b100;
   localparam logic [2:0] SS_TRIG = 3'b101;

   // Command byte that precedes the value in every DAC frame
   localparam logic [7:0] DAC_WR_CMD = 8'h13;

   // Register reset values
   localparam logic [2:0] GAIN_RST     = 3'b010;
   localparam logic [7:0] TRIG_LVL_RST = 8'h80;

   // Maps a 3-bit gain code onto the DAC value that realises that gain
   function automatic logic [7:0] gain_lut(input logic [2:0] code);
      logic [7:0] val;
      case (code)
         3'd0:    val = 8'h02;
         3'd1:    val = 8'h05;
         3'd2:    val = 8'h09;
         3'd3:    val = 8'h14;
         3'd4:    val = 8'h28;
         3'd5:    val = 8'h46;
         3'd6:    val = 8'h6B;
         default: val = 8'hDD;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cmd_cfg_regs.sv
// cmd_cfg_regs: front-end configuration register file. Each field has its
// own write enable; the dispatcher decides when a write takes effect.
module cmd_cfg_regs
   import cmd_cfg_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DEC_W  = 4,
   parameter int TPOS_W = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  gain_we,
   input  logic [1:0]            gain_ch,
   input  logic [2:0]            gain_val,
   input  logic                  trig_lvl_we,
   input  logic [7:0]            trig_lvl_val,
   input  logic                  trig_pos_we,
   input  logic [TPOS_W-1:0]     trig_pos_val,
   input  logic                  dec_we,
   input  logic [DEC_W-1:0]      dec_val,
   input  logic                  cfg_we,
   input  logic [5:0]            cfg_val,
   output logic [3*NUM_CH-1:0]   gain,
   output logic [7:0]            trig_lvl,
   output logic [TPOS_W-1:0]     trig_pos,
   output logic [DEC_W-1:0]      decimator,
   output logic [5:0]            trig_cfg
);

   // Mid-scale trigger position, cut down to the configured width
   localparam logic [TPOS_W-1:0] TPOS_RST = TPOS_W'(9'h100);

   // Field updates under their individual write enables
   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain      <= {NUM_CH{GAIN_RST}};
         trig_lvl  <= TRIG_LVL_RST;
         trig_pos  <= TPOS_RST;
         decimator <= '0;
         trig_cfg  <= '0;
      end else begin
         if (gain_we) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (gain_ch == 2'(k)) gain[3*k +: 3] <= gain_val;
            end
         end
         if (trig_lvl_we) trig_lvl  <= trig_lvl_val;
         if (trig_pos_we) trig_pos  <= trig_pos_val;
         if (dec_we)      decimator <= dec_val;
         if (cfg_we)      trig_cfg  <= cfg_val;
      end
   end

endmodule

// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: host command dispatcher. Decodes 24-bit commands, runs the
// SPI transaction a command needs to completion, updates the register file
// and returns a status/data byte for everything except dump.
// Optional feature macro: CMD_CFG_GAIN_RDBK_EN enables gain readback (0A).
module cmd_cfg_mc
   import cmd_cfg_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int TRIG_MIN = 46,
   parameter int TRIG_MAX = 201,
   parameter int DEC_W    = 4,
   parameter int TPOS_W   = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [23:0]           cmd,
   input  logic                  cmd_rdy,
   output logic                  clr_cmd_rdy,
   output logic [7:0]            resp_data,
   output logic                  send_resp,
   input  logic                  resp_sent,
   output logic [2:0]            ss,
   output logic                  wrt_SPI,
   output logic [15:0]           SPI_data,
   input  logic                  SPI_done,
   input  logic [7:0]            EEP_data,
   output logic                  dump_en,
   output logic [1:0]            dump_chan,
   input  logic                  dump_done,
   output logic [3*NUM_CH-1:0]   gain,
   output logic [7:0]            trig_lvl,
   output logic [TPOS_W-1:0]     trig_pos,
   output logic [DEC_W-1:0]      decimator,
   output logic [5:0]            trig_cfg
);

   localparam logic [7:0] TRIG_MIN_B = 8'(TRIG_MIN);
   localparam logic [7:0] TRIG_MAX_B = 8'(TRIG_MAX);
   localparam logic [2:0] NUM_CH_B   = 3'(NUM_CH);

   state_t      state, state_d;
   logic [23:0] cmd_q;

   logic        clr_d, send_d, wrt_d, dump_en_d;
   logic [2:0]  ss_d;
   logic [15:0] spi_d;
   logic [7:0]  resp_d;
   logic [1:0]  dump_chan_d;

   logic gain_we, trig_lvl_we, trig_pos_we, dec_we, cfg_we;

   // Command field decode from the latched command
   logic [7:0] opcode, byte2, byte3, trig_clamped;
   logic [1:0] cc;
   logic [2:0] ggg;
   logic       cc_ok;

   assign opcode = cmd_q[23:16];
   assign byte2  = cmd_q[15:8];
   assign byte3  = cmd_q[7:0];
   assign cc     = byte2[1:0];
   assign ggg    = byte2[4:2];
   // Channel 3 is never addressable, even with four channels fitted
   assign cc_ok  = ({1'b0, cc} < NUM_CH_B) && (cc != 2'b11);
   assign trig_clamped = (byte3 < TRIG_MIN_B) ? TRIG_MIN_B :
                         (byte3 > TRIG_MAX_B) ? TRIG_MAX_B : byte3;

   // byte2[7:6] carry no meaning for any opcode
   logic unused_byte2_hi;
   assign unused_byte2_hi = ^byte2[7:6];

`ifdef CMD_CFG_GAIN_RDBK_EN
   // Selects the gain code of channel cc for readback
   logic [2:0] gain_rd;
   always_comb begin
      gain_rd = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cc == 2'(k)) gain_rd = gain[3*k +: 3];
      end
   end
`endif

   // Command capture; only an accepted command is latched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      cmd_q <= '0;
      else if (state == IDLE && cmd_rdy) cmd_q <= cmd;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state, next-output and register write-enable decode
   // NOTE: every signal gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state;
      clr_d       = 1'b0;
      send_d      = 1'b0;
      wrt_d       = 1'b0;
      dump_en_d   = 1'b0;
      ss_d        = ss;
      spi_d       = SPI_data;
      resp_d      = resp_data;
      dump_chan_d = dump_chan;
      gain_we     = 1'b0;
      trig_lvl_we = 1'b0;
      trig_pos_we = 1'b0;
      dec_we      = 1'b0;
      cfg_we      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_rdy) begin
               clr_d   = 1'b1;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            state_d = RESP;
            resp_d  = NAK;
            case (opcode)
               OP_DUMP: begin
                  if (cc_ok) begin
                     dump_en_d   = 1'b1;
                     dump_chan_d = cc;
                     state_d     = DUMP_WAIT;
                  end
               end
               OP_GAIN: begin
                  if (cc_ok) begin
                     ss_d    = {1'b0, cc};
                     spi_d   = {DAC_WR_CMD, gain_lut(ggg)};
                     wrt_d   = 1'b1;
                     state_d = SPI_WAIT;
                  end
               end
               OP_TRIG_LVL: begin
                  ss_d    = SS_TRIG;
                  spi_d   = {DAC_WR_CMD, trig_clamped};
                  wrt_d   = 1'b1;
                  state_d = SPI_WAIT;
               end
               OP_TRIG_POS: begin
                  trig_pos_we = 1'b1;
                  resp_d      = ACK;
               end
               OP_DEC: begin
                  dec_we = 1'b1;
                  resp_d = ACK;
               end
               OP_TRIG_CFG: begin
                  cfg_we = 1'b1;
                  resp_d = ACK;
               end
               OP_CFG_RD: resp_d = {2'b00, trig_cfg};
               OP_EEP_WR: begin
                  ss_d    = SS_EEP;
                  spi_d   = {2'b01, byte2[5:0], byte3};
                  wrt_d   = 1'b1;
                  state_d = SPI_WAIT;
               end
               OP_EEP_RD: begin
                  ss_d    = SS_EEP;
                  spi_d   = {2'b00, byte2[5:0], 8'h00};
                  wrt_d   = 1'b1;
                  state_d = SPI_WAIT;
               end
`ifdef CMD_CFG_GAIN_RDBK_EN
               OP_GAIN_RD: begin
                  if (cc_ok) resp_d = {5'b0, gain_rd};
               end
`endif
               default: ;
            endcase
         end
         SPI_WAIT: begin
            // DAC values commit only once the frame has actually gone out
            if (SPI_done) begin
               ss_d        = SS_NONE;
               state_d     = RESP;
               resp_d      = (opcode == OP_EEP_RD) ? EEP_data : ACK;
               gain_we     = (opcode == OP_GAIN);
               trig_lvl_we = (opcode == OP_TRIG_LVL);
            end
         end
         DUMP_WAIT: begin
            if (dump_done) state_d = IDLE;
         end
         RESP: begin
            send_d  = 1'b1;
            state_d = RESP_WAIT;
         end
         RESP_WAIT: begin
            if (resp_sent) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
         wrt_SPI     <= 1'b0;
         dump_en     <= 1'b0;
         ss          <= SS_NONE;
         SPI_data    <= '0;
         resp_data   <= '0;
         dump_chan   <= '0;
      end else begin
         clr_cmd_rdy <= clr_d;
         send_resp   <= send_d;
         wrt_SPI     <= wrt_d;
         dump_en     <= dump_en_d;
         ss          <= ss_d;
         SPI_data    <= spi_d;
         resp_data   <= resp_d;
         dump_chan   <= dump_chan_d;
      end
   end

   cmd_cfg_regs #(
      .NUM_CH (NUM_CH),
      .DEC_W  (DEC_W),
      .TPOS_W (TPOS_W)
   ) u_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .gain_we      (gain_we),
      .gain_ch      (cc),
      .gain_val     (ggg),
      .trig_lvl_we  (trig_lvl_we),
      .trig_lvl_val (trig_clamped),
      .trig_pos_we  (trig_pos_we),
      .trig_pos_val (cmd_q[TPOS_W-1:0]),
      .dec_we       (dec_we),
      .dec_val      (cmd_q[DEC_W-1:0]),
      .cfg_we       (cfg_we),
      .cfg_val      (byte2[5:0]),
      .gain         (gain),
      .trig_lvl     (trig_lvl),
      .trig_pos     (trig_pos),
      .decimator    (decimator),
      .trig_cfg     (trig_cfg)
   );

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// tb_cmd_cfg_mc: directed bench for cmd_cfg_mc. Expected response bytes go
// into a scoreboard queue as commands are issued and are popped whenever
// the DUT raises send_resp.
module tb_cmd_cfg_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] cmd;
   logic        cmd_rdy, clr_cmd_rdy;
   logic [7:0]  resp_data;
   logic        send_resp, resp_sent;
   logic [2:0]  ss;
   logic        wrt_SPI, SPI_done;
   logic [15:0] SPI_data;
   logic [7:0]  EEP_data;
   logic        dump_en, dump_done;
   logic [1:0]  dump_chan;
   logic [8:0]  gain;
   logic [7:0]  trig_lvl;
   logic [8:0]  trig_pos;
   logic [3:0]  decimator;
   logic [5:0]  trig_cfg;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [7:0] sb[$];

   cmd_cfg_mc #(
      .NUM_CH(3), .TRIG_MIN(46), .TRIG_MAX(201), .DEC_W(4), .TPOS_W(9)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
      .resp_sent(resp_sent), .ss(ss), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data),
      .SPI_done(SPI_done), .EEP_data(EEP_data), .dump_en(dump_en),
      .dump_chan(dump_chan), .dump_done(dump_done), .gain(gain),
      .trig_lvl(trig_lvl), .trig_pos(trig_pos), .decimator(decimator),
      .trig_cfg(trig_cfg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return clr_cmd_rdy;
         1:       return send_resp;
         2:       return wrt_SPI;
         default: return dump_en;
      endcase
   endfunction

   // Bounded wait for a DUT pulse; an expired budget shows up as a failed check
   task automatic wait_high(input string tag, input int sel);
      int n = 0;
      while (sig(sel) !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check(tag, {31'b0, sig(sel)}, 32'd1);
   endtask

   task automatic send_cmd(input logic [23:0] c);
      cmd     = c;
      cmd_rdy = 1'b1;
      tick();
      wait_high("clr_cmd_rdy", 0);
      cmd_rdy = 1'b0;
   endtask

   task automatic finish_resp();
      wait_high("send_resp", 1);
      tick();
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
   endtask

   task automatic spi_finish(input logic [7:0] eep);
      EEP_data = eep;
      SPI_done = 1'b1;
      tick();
      SPI_done = 1'b0;
      check("ss_release", {29'b0, ss}, 32'h7);
   endtask

   // Scoreboard: every response byte must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && send_resp) begin
         logic [31:0] exp;
         exp = (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'h100;
         check("resp_data", {24'b0, resp_data}, exp);
      end
   end

   initial begin
      rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; resp_sent = 1'b0;
      SPI_done = 1'b0; EEP_data = '0; dump_done = 1'b0;
      tick(); tick();

      // Reset values
      check("rst_ss",        {29'b0, ss},        32'h7);
      check("rst_pulses",    {28'b0, clr_cmd_rdy, send_resp, wrt_SPI, dump_en}, 32'h0);
      check("rst_spi_data",  {16'b0, SPI_data},  32'h0);
      check("rst_resp_data", {24'b0, resp_data}, 32'h0);
      check("rst_dump_chan", {30'b0, dump_chan}, 32'h0);
      check("rst_gain",      {23'b0, gain},      32'h092);
      check("rst_trig_lvl",  {24'b0, trig_lvl},  32'h80);
      check("rst_trig_pos",  {23'b0, trig_pos},  32'h100);
      check("rst_decimator", {28'b0, decimator}, 32'h0);
      check("rst_trig_cfg",  {26'b0, trig_cfg},  32'h0);
      rst_n = 1'b1;
      tick();

      // Opcode 04: exact latency from cmd_rdy to send_resp
      sb.push_back(8'hA5);
      cmd = 24'h04_01_23; cmd_rdy = 1'b1;
      tick();
      check("lat_clr", {31'b0, clr_cmd_rdy}, 32'd1);
      cmd_rdy = 1'b0;
      tick();
      check("lat_no_resp_yet", {31'b0, send_resp}, 32'd0);
      check("trig_pos_123",    {23'b0, trig_pos},  32'h123);
      tick();
      check("lat_send_resp", {31'b0, send_resp}, 32'd1);
      finish_resp();

      // Opcode 02: gain code 3 on channel 1, committed only on SPI_done
      sb.push_back(8'hA5);
      send_cmd(24'h02_0D_00);
      wait_high("gain_wrt", 2);
      check("gain_ss",  {29'b0, ss},       32'h1);
      check("gain_spi", {16'b0, SPI_data}, 32'h1314);
      tick(); tick();
      check("gain_ss_hold", {29'b0, ss}, 32'h1);
      check("gain_pre_done", {23'b0, gain}, 32'h092);
      spi_finish(8'h00);
      check("gain_post_done", {23'b0, gain}, 32'h09A);
      finish_resp();

      // Opcode 03: clamp low then high
      sb.push_back(8'hA5);
      send_cmd(24'h03_00_10);
      wait_high("tl_lo_wrt", 2);
      check("tl_lo_ss",  {29'b0, ss},       32'h5);
      check("tl_lo_spi", {16'b0, SPI_data}, 32'h132E);
      spi_finish(8'h00);
      check("tl_lo_lvl", {24'b0, trig_lvl}, 32'h2E);
      finish_resp();
      sb.push_back(8'hA5);
      send_cmd(24'h03_00_F0);
      wait_high("tl_hi_wrt", 2);
      check("tl_hi_spi", {16'b0, SPI_data}, 32'h13C9);
      spi_finish(8'h00);
      check("tl_hi_lvl", {24'b0, trig_lvl}, 32'hC9);
      finish_resp();

      // Opcode 09: EEPROM read; a command pending meanwhile waits for IDLE
      sb.push_back(8'h5A);
      send_cmd(24'h09_15_00);
      wait_high("eep_rd_wrt", 2);
      check("eep_rd_ss",  {29'b0, ss},       32'h4);
      check("eep_rd_spi", {16'b0, SPI_data}, 32'h1500);
      cmd = 24'h04_00_07; cmd_rdy = 1'b1;
      tick(); tick(); tick();
      check("pend_clr_spi", {31'b0, clr_cmd_rdy}, 32'd0);
      spi_finish(8'h5A);
      finish_resp();
      check("pend_clr_resp", {31'b0, clr_cmd_rdy}, 32'd0);
      sb.push_back(8'hA5);
      wait_high("pend_clr", 0);
      cmd_rdy = 1'b0;
      finish_resp();
      check("pend_trig_pos", {23'b0, trig_pos}, 32'h007);

      // Opcode 08: EEPROM write; resp_sent coinciding with SPI_done is ignored
      sb.push_back(8'hA5);
      send_cmd(24'h08_2A_C3);
      wait_high("eep_wr_wrt", 2);
      check("eep_wr_ss",  {29'b0, ss},       32'h4);
      check("eep_wr_spi", {16'b0, SPI_data}, 32'h6AC3);
      resp_sent = 1'b1;
      spi_finish(8'h00);
      resp_sent = 1'b0;
      finish_resp();

      // Opcodes 05, 06, 07
      sb.push_back(8'hA5);
      send_cmd(24'h05_00_0B);
      finish_resp();
      check("decimator", {28'b0, decimator}, 32'hB);
      sb.push_back(8'hA5);
      send_cmd(24'h06_3F_00);
      finish_resp();
      check("trig_cfg", {26'b0, trig_cfg}, 32'h3F);
      sb.push_back(8'h3F);
      send_cmd(24'h07_00_00);
      finish_resp();

      // NAK cases: invalid channel on dump/gain, undefined opcode, readback
      sb.push_back(8'hEE);
      send_cmd(24'h01_03_00);
      tick();
      check("nak_no_dump", {31'b0, dump_en}, 32'd0);
      finish_resp();
      sb.push_back(8'hEE);
      send_cmd(24'h02_0F_00);
      tick();
      check("nak_no_wrt", {31'b0, wrt_SPI}, 32'd0);
      finish_resp();
      check("nak_gain_kept", {23'b0, gain}, 32'h09A);
      sb.push_back(8'hEE);
      send_cmd(24'h33_00_00);
      finish_resp();
`ifdef CMD_CFG_GAIN_RDBK_EN
      sb.push_back(8'h03);
`else
      sb.push_back(8'hEE);
`endif
      send_cmd(24'h0A_01_00);
      finish_resp();

      // Dump on channel 2: no response, next command held until dump_done
      send_cmd(24'h01_02_00);
      tick();
      check("dump_en",   {31'b0, dump_en},   32'd1);
      check("dump_chan", {30'b0, dump_chan}, 32'h2);
      cmd = 24'h07_00_00; cmd_rdy = 1'b1;
      tick(); tick(); tick();
      check("dump_en_pulse", {31'b0, dump_en},     32'd0);
      check("dump_hold_clr", {31'b0, clr_cmd_rdy}, 32'd0);
      dump_done = 1'b1;
      tick();
      dump_done = 1'b0;
      sb.push_back(8'h3F);
      wait_high("post_dump_clr", 0);
      cmd_rdy = 1'b0;
      finish_resp();

      // Reset while waiting on the SPI master
      send_cmd(24'h03_00_80);
      wait_high("mid_rst_wrt", 2);
      check("mid_rst_spi", {16'b0, SPI_data}, 32'h1380);
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ss",       {29'b0, ss},        32'h7);
      check("mid_rst_spi_data", {16'b0, SPI_data},  32'h0);
      check("mid_rst_gain",     {23'b0, gain},      32'h092);
      check("mid_rst_regs",     {trig_lvl, 1'b0, trig_pos, decimator, trig_cfg, 4'b0}, {8'h80, 1'b0, 9'h100, 4'h0, 6'h00, 4'b0});
      tick();
      rst_n = 1'b1;
      tick();
      sb.push_back(8'hA5);
      send_cmd(24'h04_01_23);
      finish_resp();
      check("post_rst_trig_pos", {23'b0, trig_pos}, 32'h123);

      tick(); tick();
      check("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
